// File: rtl/pq_pkg.sv
// Shared types and defaults for the priQueue sequencing controller.
package pq_pkg;

    localparam int PQ_DEPTH = 6;

    typedef enum logic {
        IDLE = 1'b0,
        CMD  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_INS = 2'd0,
        OP_DEQ = 2'd1,
        OP_CLR = 2'd2
    } op_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr,
// plus the pointer value that follows the winner.
module rr_arb #(
    parameter  int NPROD = 2,
    localparam int PW    = (NPROD > 1) ? $clog2(NPROD) : 1
) (
    input  logic [NPROD-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [NPROD-1:0] grant,
    output logic [PW-1:0]    next_ptr
);

    int   dist_s;
    int   best_dist_s;
    int   best_idx_s;
    logic found_s;

    // Find the requester with the smallest rotational distance from ptr.
    always_comb begin
        dist_s      = 0;
        best_dist_s = NPROD;
        best_idx_s  = 0;
        for (int i = 0; i < NPROD; i++) begin
            dist_s = (i + NPROD - int'(ptr)) % NPROD;
            if (en && req[i] && (dist_s < best_dist_s)) begin
                best_dist_s = dist_s;
                best_idx_s  = i;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    assign found_s  = (best_dist_s < NPROD);
    assign next_ptr = found_s ? PW'((best_idx_s + 1) % NPROD) : ptr;

    // Expand the winning index into a one-hot grant.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NPROD; i++) begin
            grant[i] = found_s && (best_idx_s == i);
        end
    end

endmodule

// File: rtl/pq_ctrl.sv
// Arbitrates NPROD producers and one consumer onto a priQueue, issuing one
// registered command pulse per two cycles and tracking occupancy.
module pq_ctrl
    import pq_pkg::*;
#(
    parameter int W     = 1,
    parameter int DEPTH = PQ_DEPTH,
    parameter int NPROD = 2
) (
    input  logic                         ck,
    input  logic                         r_n,
    input  logic [NPROD-1:0]             ins_req,
    input  logic [NPROD*W-1:0]           ins_data,
    output logic [NPROD-1:0]             ins_ack,
    input  logic                         deq_req,
    output logic                         deq_ack,
    output logic [W-1:0]                 deq_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [W-1:0]                 pq_newVal,
    output logic                         pq_loadIn,
    output logic                         pq_shiftOut,
    output logic                         pq_clear,
    input  logic [W-1:0]                 pq_top
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (NPROD > 1) ? $clog2(NPROD) : 1;

    state_t           state_r;
    op_t              op_r;
    op_t              last_op_r;
    logic [PW-1:0]    rr_ptr_r;
    logic [PW-1:0]    next_ptr_s;
    logic [CW-1:0]    count_r;
    logic [W-1:0]     newval_r;
    logic [W-1:0]     sel_data_s;
    logic             load_r;
    logic             shift_r;
    logic             clear_r;
    logic             flush_pend_r;
    logic [NPROD-1:0] grant_s;
    logic             idle_s;
    logic             full_s;
    logic             empty_s;
    logic             flush_eff_s;
    logic             ins_cand_s;
    logic             deq_cand_s;
    logic             do_deq_s;
    logic             do_ins_s;

    assign idle_s      = (state_r == IDLE);
    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    // A flush seen during CMD is remembered so a single-cycle pulse is not lost.
    assign flush_eff_s = flush | flush_pend_r;
    assign ins_cand_s  = (|ins_req) & ~full_s;
    assign deq_cand_s  = deq_req & ~empty_s;
    assign do_deq_s    = idle_s & ~flush_eff_s & deq_cand_s &
                         (~ins_cand_s | (last_op_r == OP_INS));
    assign do_ins_s    = idle_s & ~flush_eff_s & ins_cand_s & ~do_deq_s;

    rr_arb #(.NPROD(NPROD)) u_arb (
        .req      (ins_req),
        .ptr      (rr_ptr_r),
        .en       (do_ins_s),
        .grant    (grant_s),
        .next_ptr (next_ptr_s)
    );

    // Select the granted producer's data word.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NPROD; i++) begin
            sel_data_s = sel_data_s | ({W{grant_s[i]}} & ins_data[i*W +: W]);
        end
    end

    assign ins_ack     = grant_s;
    assign deq_ack     = do_deq_s;
    assign deq_data    = pq_top;
    assign count       = count_r;
    assign full        = full_s;
    assign empty       = empty_s;
    assign pq_newVal   = newval_r;
    assign pq_loadIn   = load_r;
    assign pq_shiftOut = shift_r;
    assign pq_clear    = clear_r;

    // Two-state sequencer: decide in IDLE, pulse and settle occupancy in CMD.
    always_ff @(posedge ck or negedge r_n) begin
        if (!r_n) begin
            state_r      <= IDLE;
            op_r         <= OP_INS;
            last_op_r    <= OP_INS;
            rr_ptr_r     <= {PW{1'b0}};
            count_r      <= {CW{1'b0}};
            newval_r     <= {W{1'b0}};
            load_r       <= 1'b0;
            shift_r      <= 1'b0;
            clear_r      <= 1'b0;
            flush_pend_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush_eff_s) begin
                        clear_r      <= 1'b1;
                        flush_pend_r <= 1'b0;
                        op_r         <= OP_CLR;
                        state_r      <= CMD;
                    end else if (do_ins_s) begin
                        load_r   <= 1'b1;
                        newval_r <= sel_data_s;
                        rr_ptr_r <= next_ptr_s;
                        op_r     <= OP_INS;
                        state_r  <= CMD;
                    end else if (do_deq_s) begin
                        shift_r <= 1'b1;
                        op_r    <= OP_DEQ;
                        state_r <= CMD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CMD: begin
                    load_r    <= 1'b0;
                    shift_r   <= 1'b0;
                    clear_r   <= 1'b0;
                    last_op_r <= op_r;
                    state_r   <= IDLE;
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end else begin
                        flush_pend_r <= flush_pend_r;
                    end
                    case (op_r)
                        OP_INS:  count_r <= full_s  ? count_r : count_r + CW'(1);
                        OP_DEQ:  count_r <= empty_s ? count_r : count_r - CW'(1);
                        OP_CLR:  count_r <= {CW{1'b0}};
                        default: count_r <= {CW{1'b0}};
                    endcase
                end
                default: begin
                    load_r  <= 1'b0;
                    shift_r <= 1'b0;
                    clear_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pq_ctrl.md
# pq_ctrl

Sequencing and arbitration controller for the `priQueue` sorted register queue. It shares the queue's single load port between `NPROD` producers using round-robin arbitration, and serves one consumer's remove requests. It tracks occupancy, blocks inserts when full and removes when empty, and drives `loadIn`, `shiftOut`, `clear` and `newVal` as registered one-cycle command pulses. It sits directly between the requesters and one `priQueue` instance.

## Interface
Parameters:
- `W`, default 1: data width; must match the queue's `newVal`/`top` width.
- `DEPTH`, default 6: queue capacity in entries.
- `NPROD`, default 2: number of insert requesters, minimum 1.

Ports:
- `ck`  in  1  single clock, rising edge.
- `r_n`  in  1  reset, asynchronous, active-low; it must also hold the attached queue in reset.
- `ins_req`  in  NPROD  per-producer insert request, level.
- `ins_data`  in  NPROD×W  per-producer insert value.
- `ins_ack`  out  NPROD  one-hot grant pulse; the insert is accepted in that cycle.
- `deq_req`  in  1  consumer remove request, level.
- `deq_ack`  out  1  remove accepted; `deq_data` is valid in the same cycle.
- `deq_data`  out  W  current queue head, equal to `pq_top`.
- `flush`  in  1  empty-queue request, single-cycle pulse or level.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`, `empty`  out  1  `count==DEPTH` and `count==0`.
- `pq_newVal`  out  W  registered value presented to the queue.
- `pq_loadIn`, `pq_shiftOut`, `pq_clear`  out  1  registered command pulses to the queue.
- `pq_top`  in  W  queue head.

## Operation
FSM states:
- IDLE: arbitration is evaluated here; this is the only state in which acks are issued.
- CMD: exactly one of `pq_loadIn`, `pq_shiftOut`, `pq_clear` is high for this one cycle; the FSM always returns to IDLE on the next cycle.

IDLE decision priority:
1. `flush`: no ack is issued. `pq_clear` is registered and `count` becomes 0 at the end of CMD.
2. An insert candidate exists when any `ins_req` is high and the queue is not full. A remove candidate exists when `deq_req` is high and the queue is not empty.
3. If both candidates exist, use `last_op`: if the previous command was an insert, the remove wins; otherwise the insert wins.
4. Insert grant: the round-robin arbiter picks producer i starting from `rr_ptr`. The controller asserts `ins_ack[i]`, registers `pq_newVal<=ins_data[i]` and `pq_loadIn<=1`, and sets `rr_ptr<=i+1` (mod NPROD).
5. Remove grant: the controller asserts `deq_ack` (`deq_data=pq_top` in that cycle) and registers `pq_shiftOut<=1`.
6. `count` is incremented or decremented at the end of CMD, and `last_op` is updated then.

Additional rules:
- If no candidate exists, the FSM stays in IDLE and all commands stay low.
- Requesters keep their request high until acked. A request dropped before its ack is legal and simply not served.
- Reset value of every output and register: 0. This covers the acks, all `pq_*` commands, `count`, `rr_ptr`, and `last_op=insert`; the FSM resets to IDLE. `empty=1` and `full=0` at reset.
- Reset asserted mid-CMD: the command is dropped immediately (asynchronous) and the queue is reset alongside, so `count=0` remains consistent.
- `count` never leaves the range 0..DEPTH. Inserts while full and removes while empty are never acked.

## Timing
- A grant in IDLE cycle t gives the following sequence:
  - Cycle t+1: CMD, command pulse high.
  - Edge ending t+1: the queue updates.
  - Cycle t+2: IDLE, `pq_top` and `count` are updated.
- Throughput is one operation per 2 cycles.
- `deq_data` is the head before the shift, sampled by the consumer in the ack cycle.
- Ack-to-command latency: 1 cycle. Command-to-visible-head latency: 1 cycle.
- Acks are combinational from registered state and the `*_req` inputs. Requests must not depend combinationally on acks.
- A `flush` arriving during CMD is honored in the next IDLE.

## Structure
- Package `pq_pkg`: `state_t` {IDLE, CMD}, `op_t` {OP_INS, OP_DEQ, OP_CLR}, and the default `PQ_DEPTH=6`.
- Sub-module `rr_arb` (parameter NPROD): takes the request vector, pointer and enable, and returns a one-hot grant plus the next pointer.
- Everything else lives in `pq_ctrl`.

## Test plan
All scenarios use W=4, DEPTH=6, NPROD=2, checked against a sorted-list model of the queue.
- Reset, then release → `count=0`, `empty=1`, all commands 0, `deq_ack` never asserted while `deq_req=1`.
- Both producers request continuously (data 3 and 5) → `ins_ack` alternates 01,10,01; exactly one `pq_loadIn` per 2 cycles; `count` reaches 6, `full=1`, then no further acks.
- At `count=6`, `deq_req=1` with both producers still requesting → remove acked first (`last_op`=insert), then insert and remove alternate, and `count` stays between 5 and 6.
- Insert 9, 2, 7, then remove ×3 → `deq_data` matches the model order, each `deq_ack` is followed one cycle later by `pq_shiftOut`, and `empty=1` at the end.
- `flush` in the same IDLE cycle as `ins_req` → no ack, `pq_clear` pulses in the next cycle, `count=0` in the cycle after, then the insert is acked.
- Assert `r_n=0` during a CMD cycle → `pq_loadIn` falls immediately, `count=0`, and normal operation resumes after release.
